meta_arb_wrr: RTL
=================

META_ARB_WRR -- requirements
Module: meta_arb_wrr

Interface
REQ-001 Parameter N_SRC, default 4, number of requesting metadata sources (legal 2..16).
REQ-002 Parameter DATA_BITS, default 96, width of one metadata word.
REQ-003 Parameter WGT_BITS, default 4, width of each per-source weight.
REQ-004 Port aclk  input  1  single clock; all state on rising edge.
REQ-005 Port areset  input  1  reset, asynchronous, active-high.
REQ-006 Port s_meta_valid  input  N_SRC  per-source valid; bit i = source i.
REQ-007 Port s_meta_ready  output  N_SRC  per-source ready.
REQ-008 Port s_meta_data  input  N_SRC*DATA_BITS  source i occupies bits [i*DATA_BITS +: DATA_BITS].
REQ-009 Port m_meta_valid  output  1  output valid.
REQ-010 Port m_meta_ready  input  1  output ready.
REQ-011 Port m_meta_data  output  DATA_BITS  output metadata word.
REQ-012 Port m_meta_id  output  $clog2(N_SRC)  index of the source that produced m_meta_data.
REQ-013 Port cfg_weight  input  N_SRC*WGT_BITS  per-source burst quota; source i at [i*WGT_BITS +: WGT_BITS].

Function
REQ-014 Block SHALL implement a two-state FSM: ARB and SERVE.
REQ-015 ARB: SHALL select the first source with s_meta_valid high, searching circularly from ptr+1 to ptr (wrap N_SRC-1 -> 0).
REQ-016 ARB with a source found: cur <= index, quota <= cfg_weight[cur] (value 0 treated as 1), next state SERVE; no transfer in this cycle.
REQ-017 ARB with no valid source: stay in ARB; ptr unchanged.
REQ-018 s_meta_ready SHALL be all-zero in ARB; in SERVE only bit cur may be high, equal to slot_free.
REQ-019 slot_free = !m_meta_valid | m_meta_ready (single output register stage).
REQ-020 Transfer in SERVE = s_meta_valid[cur] & slot_free; output register loads data and id=cur, m_meta_valid high next cycle (latency 1 from accept).
REQ-021 On output handshake with no new load, m_meta_valid SHALL clear next cycle; simultaneous handshake and load SHALL keep m_meta_valid high with new data (full throughput).
REQ-022 m_meta_data and m_meta_id SHALL hold stable while m_meta_valid & !m_meta_ready.
REQ-023 Each SERVE transfer decrements quota; transfer with quota==1 SHALL end the burst: ptr <= cur, next state ARB.
REQ-024 SERVE cycle with s_meta_valid[cur] low SHALL end the burst early: ptr <= cur, next state ARB, no transfer.
REQ-025 SERVE with s_meta_valid[cur] high but slot_free low SHALL stay in SERVE; quota unchanged.
REQ-026 cfg_weight SHALL be sampled only in ARB at grant; changes during SERVE affect the next grant only.
REQ-027 Quota counter SHALL be WGT_BITS wide; max burst = 2^WGT_BITS-1 beats; no wrap permitted.
REQ-028 Throughput: a burst of W beats with m_meta_ready high SHALL complete in W consecutive cycles, followed by exactly one ARB bubble cycle.
REQ-029 No source with valid held high SHALL wait more than (N_SRC-1) bursts plus N_SRC ARB cycles for a grant.

Reset
REQ-030 areset high SHALL asynchronously force: state ARB, ptr N_SRC-1 (source 0 has first priority), cur 0, quota 0.
REQ-031 During and after reset: m_meta_valid 0, m_meta_data 0, m_meta_id 0, s_meta_ready all 0.
REQ-032 Reset mid-burst SHALL discard any word in the output register; no partial burst resumes after release.
REQ-033 First grant evaluation SHALL occur on the first rising edge after areset deasserts.

Verification
REQ-034 N_SRC=4, weights all 1, all valid held, ready=1 -> m_meta_id sequence 0,1,2,3,0,... each beat separated by one bubble.
REQ-035 Weights {3,1,2,1}, all valid held, ready=1 -> ids 0,0,0,1,2,2,3 back-to-back within bursts, one bubble between bursts.
REQ-036 Source 2 only, weight 4, valid for 2 beats then low -> 2 transfers, burst ends on valid-low cycle, FSM back in ARB, next grant search starts at 3.
REQ-037 m_meta_ready held low 5 cycles with word D=0xABC pending -> m_meta_data/id stable, s_meta_ready[cur]=0, quota unchanged; ready high -> D accepted, next beat flows.
REQ-038 cfg_weight[0] changed 2->5 mid-burst of source 0 -> current burst remains 2 beats, next source 0 burst 5 beats.
REQ-039 areset pulsed mid-burst with m_meta_valid=1 -> outputs zero immediately (asynchronous), source 0 granted first after release.

Source files
------------

// File: rtl/meta_arb_wrr.sv
// ---------------------------------------------------------------------------
// meta_arb_wrr
//
// Weighted round-robin arbiter for metadata words.  N_SRC sources compete for
// one output.  A granted source keeps the output for a burst of up to
// cfg_weight[src] beats (0 counts as 1).  The burst ends early as soon as the
// source drops valid.  The round-robin pointer then advances past it.
// The output side is a single register stage.
//
// Handshake semantics (all ports): a word moves on a rising aclk edge when
// valid and ready are both high in the cycle before that edge.  A producer
// holding valid keeps its data stable until the handshake.  Ready may depend
// combinationally on the consumer's ready (s_meta_ready follows m_meta_ready).
//
// Ports
//   aclk, areset     clock, asynchronous active-high reset
//   s_meta_valid     per-source valid, bit i = source i
//   s_meta_ready     per-source ready, only the served source can be high
//   s_meta_data      source i at [i*DATA_BITS +: DATA_BITS]
//   m_meta_valid     output valid
//   m_meta_ready     output ready
//   m_meta_data      output word
//   m_meta_id        index of the source that produced m_meta_data
//   cfg_weight       source i burst quota at [i*WGT_BITS +: WGT_BITS]
//   dbg_state        current FSM state (0 = ARB, 1 = SERVE)
// ---------------------------------------------------------------------------
module meta_arb_wrr #(
    parameter int N_SRC     = 4,
    parameter int DATA_BITS = 96,
    parameter int WGT_BITS  = 4,
    localparam int ID_W     = $clog2(N_SRC)
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [N_SRC-1:0]              s_meta_valid,
    output logic [N_SRC-1:0]              s_meta_ready,
    input  logic [N_SRC*DATA_BITS-1:0]    s_meta_data,
    output logic                          m_meta_valid,
    input  logic                          m_meta_ready,
    output logic [DATA_BITS-1:0]          m_meta_data,
    output logic [ID_W-1:0]               m_meta_id,
    input  logic [N_SRC*WGT_BITS-1:0]     cfg_weight,
    output logic                          dbg_state
);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       cur_q, cur_d;
    logic [WGT_BITS-1:0]   quota_q, quota_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_BITS-1:0]  out_data_q, out_data_d;
    logic [ID_W-1:0]       out_id_q, out_id_d;

    // Unpacked views of the flat source buses.
    logic [DATA_BITS-1:0]  src_data [N_SRC];
    logic [WGT_BITS-1:0]   src_wgt  [N_SRC];

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            src_data[i] = s_meta_data[i*DATA_BITS +: DATA_BITS];
            src_wgt[i]  = cfg_weight[i*WGT_BITS +: WGT_BITS];
        end
    end

    // Circular search from ptr+1 up to and including ptr.  The candidate
    // index carries one extra bit so ptr+k cannot overflow before the wrap.
    logic             found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W:0]    cand;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_SRC)) begin
                cand = cand - (ID_W+1)'(N_SRC);
            end
            if (!found && s_meta_valid[cand[ID_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
    end

    logic slot_free;
    logic xfer;

    assign slot_free = !out_valid_q || m_meta_ready;
    assign xfer      = (state_q == ST_SERVE) && s_meta_valid[cur_q] && slot_free;

    // ---------------------------------------------------------------- state
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_ARB;
            ptr_q       <= ID_W'(N_SRC-1);
            cur_q       <= '0;
            quota_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cur_q       <= cur_d;
            quota_q     <= quota_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        quota_d = quota_q;

        case (state_q)
            ST_ARB: begin
                if (found) begin
                    cur_d   = grant_idx;
                    // A zero weight still earns a single beat.
                    quota_d = (src_wgt[grant_idx] == '0) ? WGT_BITS'(1)
                                                         : src_wgt[grant_idx];
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (!s_meta_valid[cur_q]) begin
                    ptr_d   = cur_q;
                    state_d = ST_ARB;
                end else if (slot_free) begin
                    quota_d = quota_q - WGT_BITS'(1);
                    if (quota_q == WGT_BITS'(1)) begin
                        ptr_d   = cur_q;
                        state_d = ST_ARB;
                    end
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase

        // Output register: load on transfer, otherwise drain on handshake.
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = src_data[cur_q];
            out_id_d    = cur_q;
        end else if (m_meta_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        s_meta_ready = '0;
        if (state_q == ST_SERVE) begin
            s_meta_ready[cur_q] = slot_free;
        end
    end

    assign m_meta_valid = out_valid_q;
    assign m_meta_data  = out_data_q;
    assign m_meta_id    = out_id_q;
    assign dbg_state    = state_q;

endmodule
